// File: rtl/sin_src_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// sin_src_sweep_ctrl
//
// Tone/sweep sequencer for the sine-source stimulus path. One sweep command is
// taken over a valid/ready handshake. The block then steps the source frequency
// code through N tones and holds each tone for a programmed dwell. It drives the
// source configuration bus (enable, frequency, amplitude, update strobe).
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset
//   cmd_valid    command valid
//   cmd_ready    command ready (high only in IDLE)
//   cmd_f_start  first tone frequency code
//   cmd_f_step   per-tone increment, two's complement
//   cmd_n_tones  number of tones (0 behaves as 1)
//   cmd_dwell    cycles per tone (0 behaves as 1)
//   cmd_amp      amplitude code for the whole sweep
//   abort        terminate the active sweep
//   src_en       source enable
//   src_freq     current frequency code
//   src_amp      current amplitude code
//   src_upd      one-cycle strobe: new src_freq/src_amp valid
//   step_idx     0-based index of the current tone
//   busy         high in RUN and DONE
//   done         one-cycle pulse when a sweep completes normally
//   ovf          sticky: a frequency step wrapped modulo 2^FW
// -----------------------------------------------------------------------------
module sin_src_sweep_ctrl #(
  parameter int FW = 32,
  parameter int AW = 16,
  parameter int NW = 16,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [FW-1:0] cmd_f_start,
  input  logic [FW-1:0] cmd_f_step,
  input  logic [NW-1:0] cmd_n_tones,
  input  logic [DW-1:0] cmd_dwell,
  input  logic [AW-1:0] cmd_amp,
  input  logic          abort,
  output logic          src_en,
  output logic [FW-1:0] src_freq,
  output logic [AW-1:0] src_amp,
  output logic          src_upd,
  output logic [NW-1:0] step_idx,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [FW-1:0] r_f_step;
  logic [NW-1:0] r_n_last;     // index of the final tone (N-1 after 0->1 fix-up)
  logic [DW-1:0] r_dwell_last; // reload value for the dwell counter (D-1)
  logic [DW-1:0] r_cnt;
  logic          r_src_en;
  logic [FW-1:0] r_src_freq;
  logic [AW-1:0] r_src_amp;
  logic          r_src_upd;
  logic [NW-1:0] r_step_idx;
  logic          r_busy;
  logic          r_done;
  logic          r_ovf;

  logic [FW:0]   w_sum;
  logic          w_wrap;
  logic          w_last_tone;

  // One extra bit captures the carry of the wrapping add. With a negative step,
  // a borrow is the absence of a carry out of the unsigned add.
  assign w_sum       = {1'b0, r_src_freq} + {1'b0, r_f_step};
  assign w_wrap      = r_f_step[FW-1] ? ~w_sum[FW] : w_sum[FW];
  assign w_last_tone = (r_step_idx == r_n_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_f_step     <= '0;
      r_n_last     <= '0;
      r_dwell_last <= '0;
      r_cnt        <= '0;
      r_src_en     <= 1'b0;
      r_src_freq   <= '0;
      r_src_amp    <= '0;
      r_src_upd    <= 1'b0;
      r_step_idx   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      // Strobes default low; only the branches below raise them.
      r_src_upd <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_state      <= S_RUN;
            r_f_step     <= cmd_f_step;
            r_n_last     <= (cmd_n_tones == '0) ? '0 : cmd_n_tones - NW'(1);
            r_dwell_last <= (cmd_dwell == '0) ? '0 : cmd_dwell - DW'(1);
            r_cnt        <= (cmd_dwell == '0) ? '0 : cmd_dwell - DW'(1);
            r_src_en     <= 1'b1;
            r_src_freq   <= cmd_f_start;
            r_src_amp    <= cmd_amp;
            r_src_upd    <= 1'b1;
            r_step_idx   <= '0;
            r_busy       <= 1'b1;
            r_ovf        <= 1'b0;
          end
        end

        S_RUN: begin
          // abort outranks both the tone step and the DONE transition.
          if (abort) begin
            r_state  <= S_IDLE;
            r_src_en <= 1'b0;
            r_busy   <= 1'b0;
          end else if (r_cnt == '0) begin
            if (w_last_tone) begin
              r_state  <= S_DONE;
              r_src_en <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_src_freq <= w_sum[FW-1:0];
              r_step_idx <= r_step_idx + NW'(1);
              r_src_upd  <= 1'b1;
              r_cnt      <= r_dwell_last;
              if (w_wrap) r_ovf <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - DW'(1);
          end
        end

        S_DONE: begin
          // Single-cycle state; abort here lands in the same IDLE outcome.
          r_state  <= S_IDLE;
          r_src_en <= 1'b0;
          r_busy   <= 1'b0;
        end

        default: begin
          r_state  <= S_IDLE;
          r_src_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign src_en    = r_src_en;
  assign src_freq  = r_src_freq;
  assign src_amp   = r_src_amp;
  assign src_upd   = r_src_upd;
  assign step_idx  = r_step_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_sin_src_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sin_src_sweep_ctrl
//
// Directed bench for sin_src_sweep_ctrl. The basic sweep is driven from a table
// of per-cycle {abort input, expected outputs} records. Short hand-written
// sequences cover degenerate counts, wrap/ovf, abort, backpressure and reset.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_sin_src_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_f_start;
  logic [31:0] cmd_f_step;
  logic [15:0] cmd_n_tones;
  logic [23:0] cmd_dwell;
  logic [15:0] cmd_amp;
  logic        abort;
  logic        src_en;
  logic [31:0] src_freq;
  logic [15:0] src_amp;
  logic        src_upd;
  logic [15:0] step_idx;
  logic        busy;
  logic        done;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  sin_src_sweep_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_f_start(cmd_f_start), .cmd_f_step(cmd_f_step),
    .cmd_n_tones(cmd_n_tones), .cmd_dwell(cmd_dwell), .cmd_amp(cmd_amp),
    .abort(abort),
    .src_en(src_en), .src_freq(src_freq), .src_amp(src_amp),
    .src_upd(src_upd), .step_idx(step_idx),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic        en;
    logic        upd;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [31:0] freq;
    logic [15:0] amp;
    logic [15:0] idx;
  } exp_t;

  typedef struct {
    logic abort;
    exp_t e;
  } vec_t;

  vec_t vb[14];

  function automatic exp_t mke(input logic rdy, input logic en, input logic upd,
                               input logic bsy, input logic dn, input logic ov,
                               input logic [31:0] fr, input logic [15:0] am,
                               input logic [15:0] ix);
    exp_t e;
    e.rdy = rdy; e.en = en; e.upd = upd; e.busy = bsy; e.done = dn;
    e.ovf = ov; e.freq = fr; e.amp = am; e.idx = ix;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input exp_t e);
    chk({nm, ".cmd_ready"}, 64'(cmd_ready), 64'(e.rdy));
    chk({nm, ".src_en"},    64'(src_en),    64'(e.en));
    chk({nm, ".src_upd"},   64'(src_upd),   64'(e.upd));
    chk({nm, ".busy"},      64'(busy),      64'(e.busy));
    chk({nm, ".done"},      64'(done),      64'(e.done));
    chk({nm, ".ovf"},       64'(ovf),       64'(e.ovf));
    chk({nm, ".src_freq"},  64'(src_freq),  64'(e.freq));
    chk({nm, ".src_amp"},   64'(src_amp),   64'(e.amp));
    chk({nm, ".step_idx"},  64'(step_idx),  64'(e.idx));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one edge; on return the bench sits in cycle T+1.
  task automatic start(input logic [31:0] fs, input logic [31:0] fst,
                       input logic [15:0] n, input logic [23:0] d,
                       input logic [15:0] am);
    cmd_f_start = fs; cmd_f_step = fst; cmd_n_tones = n; cmd_dwell = d;
    cmd_amp = am; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Basic sweep: f_start=1000, f_step=250, N=4, D=3, amp=0x0ABC.
    // Row i is cycle T+1+i.
    for (int i = 0; i < 14; i++) vb[i].abort = 1'b0;
    vb[0].e  = mke(0, 1, 1, 1, 0, 0, 1000, 16'h0ABC, 0);
    vb[1].e  = mke(0, 1, 0, 1, 0, 0, 1000, 16'h0ABC, 0);
    vb[2].e  = mke(0, 1, 0, 1, 0, 0, 1000, 16'h0ABC, 0);
    vb[3].e  = mke(0, 1, 1, 1, 0, 0, 1250, 16'h0ABC, 1);
    vb[4].e  = mke(0, 1, 0, 1, 0, 0, 1250, 16'h0ABC, 1);
    vb[5].e  = mke(0, 1, 0, 1, 0, 0, 1250, 16'h0ABC, 1);
    vb[6].e  = mke(0, 1, 1, 1, 0, 0, 1500, 16'h0ABC, 2);
    vb[7].e  = mke(0, 1, 0, 1, 0, 0, 1500, 16'h0ABC, 2);
    vb[8].e  = mke(0, 1, 0, 1, 0, 0, 1500, 16'h0ABC, 2);
    vb[9].e  = mke(0, 1, 1, 1, 0, 0, 1750, 16'h0ABC, 3);
    vb[10].e = mke(0, 1, 0, 1, 0, 0, 1750, 16'h0ABC, 3);
    vb[11].e = mke(0, 1, 0, 1, 0, 0, 1750, 16'h0ABC, 3);
    vb[12].e = mke(0, 0, 0, 1, 1, 0, 1750, 16'h0ABC, 3);
    vb[13].e = mke(1, 0, 0, 0, 0, 0, 1750, 16'h0ABC, 3);

    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_f_start = '0; cmd_f_step = '0; cmd_n_tones = '0; cmd_dwell = '0; cmd_amp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", mke(1, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    // abort in IDLE must do nothing
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_all("idle_abort", mke(1, 0, 0, 0, 0, 0, 0, 0, 0));

    // Basic sweep from the table
    start(1000, 250, 4, 3, 16'h0ABC);
    for (int i = 0; i < 14; i++) begin
      chk_all($sformatf("basic[T+%0d]", i + 1), vb[i].e);
      abort = vb[i].abort;
      step();
      abort = 1'b0;
    end

    // Degenerate counts: N=0, D=0
    start(7, 5, 0, 0, 16'h0005);
    chk_all("degen[T+1]", mke(0, 1, 1, 1, 0, 0, 7, 5, 0));
    step();
    chk_all("degen[T+2]", mke(0, 0, 0, 1, 1, 0, 7, 5, 0));
    step();
    chk_all("degen[T+3]", mke(1, 0, 0, 0, 0, 0, 7, 5, 0));

    // Negative wrap: 100 + (2^32-200) -> 2^32-100 with ovf
    start(100, 32'hFFFF_FF38, 2, 2, 16'h0011);
    chk_all("wrap[T+1]", mke(0, 1, 1, 1, 0, 0, 100, 16'h0011, 0));
    step(); step();
    chk("wrap[T+3].upd",  64'(src_upd),  64'(1));
    chk("wrap[T+3].freq", 64'(src_freq), 64'(32'hFFFF_FF9C));
    chk("wrap[T+3].idx",  64'(step_idx), 64'(1));
    step();
    chk_all("wrap[T+4]", mke(0, 1, 0, 1, 0, 1, 32'hFFFF_FF9C, 16'h0011, 1));
    step();
    chk_all("wrap[T+5]", mke(0, 0, 0, 1, 1, 1, 32'hFFFF_FF9C, 16'h0011, 1));
    step();
    chk_all("wrap[T+6]", mke(1, 0, 0, 0, 0, 1, 32'hFFFF_FF9C, 16'h0011, 1));
    step();
    chk("wrap_sticky.ovf", 64'(ovf), 64'(1));
    // Re-run with a small positive step: ovf clears at accept
    start(100, 50, 2, 1, 16'h0011);
    chk("rerun[T+1].ovf", 64'(ovf), 64'(0));
    step();
    chk("rerun[T+2].freq", 64'(src_freq), 64'(150));
    chk("rerun[T+2].ovf",  64'(ovf),      64'(0));
    repeat (3) step();
    chk("rerun_idle.rdy", 64'(cmd_ready), 64'(1));

    // Abort during RUN at T+5
    start(1000, 250, 4, 3, 16'h0ABC);
    repeat (4) step();            // now in cycle T+5
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_all("abort[T+6]", mke(1, 0, 0, 0, 0, 0, 1250, 16'h0ABC, 1));
    step();
    chk_all("abort[T+7]", mke(1, 0, 0, 0, 0, 0, 1250, 16'h0ABC, 1));

    // Abort coinciding with the final dwell expiry (cycle T+12)
    start(1000, 250, 4, 3, 16'h0ABC);
    repeat (11) step();
    chk("abort_last[T+12].idx", 64'(step_idx), 64'(3));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_all("abort_last[T+13]", mke(1, 0, 0, 0, 0, 0, 1750, 16'h0ABC, 3));
    step();
    chk("abort_last[T+14].done", 64'(done), 64'(0));

    // Backpressure: a new command is held valid throughout a sweep
    start(1000, 250, 4, 3, 16'h0ABC);
    cmd_f_start = 5000; cmd_f_step = 1; cmd_n_tones = 1; cmd_dwell = 1;
    cmd_amp = 16'h0007; cmd_valid = 1'b1;
    chk("bp[T+1].rdy", 64'(cmd_ready), 64'(0));
    repeat (3) step();
    chk_all("bp[T+4]", mke(0, 1, 1, 1, 0, 0, 1250, 16'h0ABC, 1));
    repeat (9) step();
    chk_all("bp[T+13]", mke(0, 0, 0, 1, 1, 0, 1750, 16'h0ABC, 3));
    step();
    chk_all("bp[T+14]", mke(1, 0, 0, 0, 0, 0, 1750, 16'h0ABC, 3));
    step();
    cmd_valid = 1'b0;
    chk_all("bp[T+15]", mke(0, 1, 1, 1, 0, 0, 5000, 16'h0007, 0));
    step();
    chk_all("bp[T+16]", mke(0, 0, 0, 1, 1, 0, 5000, 16'h0007, 0));
    step();

    // Synchronous reset mid-RUN at T+4
    start(1000, 250, 4, 3, 16'h0ABC);
    repeat (3) step();
    chk("rst_mid[T+4].upd", 64'(src_upd), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("rst_mid[T+5]", mke(1, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    chk("rst_mid[T+6].done", 64'(done), 64'(0));
    // Following command runs normally: f=10, step=3, N=2, D=1
    start(10, 3, 2, 1, 16'h0022);
    chk_all("post_rst[T+1]", mke(0, 1, 1, 1, 0, 0, 10, 16'h0022, 0));
    step();
    chk_all("post_rst[T+2]", mke(0, 1, 1, 1, 0, 0, 13, 16'h0022, 1));
    step();
    chk_all("post_rst[T+3]", mke(0, 0, 0, 1, 1, 0, 13, 16'h0022, 1));
    step();
    chk_all("post_rst[T+4]", mke(1, 0, 0, 0, 0, 0, 13, 16'h0022, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
